// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time and a one-cycle turnaround gap.
// The winner index is registered, and each lane decodes it into its own one-hot grant bit.

module rr_arb_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             vld,
  output logic             gnt
);
  assign gnt = vld && (idx == IDX_W'(LANE));
endmodule

module rr_arbiter8 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);
  localparam int NUM_LANES = 8;
  localparam int IDX_W     = 3;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                 state, state_d;
  logic [IDX_W-1:0]       ptr, ptr_d, idx_d, win_idx;
  logic                   win_vld, vld_d, to_d;
  logic [CNT_W-1:0]       hold_cnt, cnt_d;
  logic [NUM_LANES-1:0]   ereq, grant_d;
  logic                   owner_req, at_limit;

  assign ereq      = req & mask;
  assign owner_req = ereq[grant_idx];
  assign at_limit  = HOLD_EN && (hold_cnt == HOLD_LIM);

  // Rotating priority search: walk from the farthest offset back to ptr,
  // so the nearest set request is the last one written.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_vld = 1'b0;
    win_idx = ptr;
    for (int i = NUM_LANES-1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (ereq[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, GAP: state_d = win_vld ? GRANT : IDLE;
      GRANT:     if (!owner_req || at_limit) state_d = GAP;
      default:   state_d = IDLE;
    endcase
  end

  // Next register values. Release takes priority over the hold limit, so a
  // coincident release never raises timeout.
  always_comb begin
    idx_d = grant_idx;
    vld_d = 1'b0;
    to_d  = 1'b0;
    cnt_d = hold_cnt;
    ptr_d = ptr;
    unique case (state)
      IDLE, GAP: begin
        if (win_vld) begin
          idx_d = win_idx;
          vld_d = 1'b1;
          cnt_d = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_d = grant_idx + IDX_W'(1);
        end else if (at_limit) begin
          ptr_d = grant_idx + IDX_W'(1);
          to_d  = 1'b1;
        end else begin
          vld_d = 1'b1;
          if (hold_cnt != '1) cnt_d = hold_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_arb_lane #(.LANE(g), .IDX_W(IDX_W)) u_lane (
      .idx (idx_d),
      .vld (vld_d),
      .gnt (grant_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= '0;
    end else begin
      grant       <= grant_d;
      grant_idx   <= idx_d;
      grant_valid <= vld_d;
      timeout     <= to_d;
      hold_cnt    <= cnt_d;
      ptr         <= ptr_d;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a short hold limit (MAX_HOLD = 4).
module tb_rr_arbiter8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid, timeout;
  int         n_chk = 0;
  int         n_fail = 0;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .mask        (mask),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic v, input logic to);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_idx"},   32'(grant_idx), 32'(idx));
    check({tag, "_valid"}, 32'(grant_valid), 32'(v));
    check({tag, "_to"},    32'(timeout), 32'(to));
  endtask

  initial begin
    rst_n = 1'b0; req = 8'hFF; mask = 8'hFF;
    repeat (3) step();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1; req = 8'h00;
    repeat (2) step();
    chk_out("post_reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request: req[5] for 3 sampled edges.
    req = 8'h20;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("single", 8'h20, 3'd5, 1'b1, 1'b0);
    end
    req = 8'h00;
    step();
    chk_out("single_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    step();
    // ptr is now 6: bit 6 beats bit 0.
    req = 8'h41;
    step();
    chk_out("ptr_after_5", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    repeat (2) step();

    // Full contention from a fresh reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_out("cont", 8'(1 << (g % 8)), 3'(g % 8), 1'b1, 1'b0);
      end
      step();
      chk_out("cont_gap", 8'h00, 3'(g % 8), 1'b0, 1'b1);
    end

    // Wrap-around: 7 released leaves ptr = 0, so 0 beats 7.
    req = 8'h80;
    step();
    chk_out("wrap_7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_out("wrap_rel", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'h81;
    step();
    chk_out("wrap_0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    repeat (2) step();

    // Mask revoke: ptr = 1, requesters 2 and 5.
    req = 8'h24;
    step();
    chk_out("mask_g2", 8'h04, 3'd2, 1'b1, 1'b0);
    step();
    chk_out("mask_g2b", 8'h04, 3'd2, 1'b1, 1'b0);
    mask = 8'hFB;
    step();
    chk_out("mask_drop", 8'h00, 3'd2, 1'b0, 1'b0);
    step();
    chk_out("mask_next", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00; mask = 8'hFF;
    repeat (2) step();

    // Asynchronous reset mid-grant.
    req = 8'h10;
    step();
    chk_out("async_pre", 8'h10, 3'd4, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1; req = 8'h48;
    step();
    chk_out("post_async", 8'h08, 3'd3, 1'b1, 1'b0);

    // Release coincides with the hold limit: release wins, no timeout.
    repeat (3) step();
    chk_out("coinc_hold", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h40;
    step();
    chk_out("coinc_rel", 8'h00, 3'd3, 1'b0, 1'b0);
    step();
    chk_out("coinc_next", 8'h40, 3'd6, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one resource selected by the 3-to-8 decode path among eight requesters. It picks a winner index, registers it, and drives both the 3-bit index and its one-hot decode (the decoder's function) as the grant. A hold counter bounds grant length, and a mandatory one-cycle turnaround separates consecutive grants. It sits between requesting units and the shared resource's select/enable lines.

## Interface
- MAX_HOLD, default 15: maximum consecutive grant cycles per winner; 0 = unlimited (no timeout).
- CNT_W, default 4: hold counter width; MAX_HOLD must be ≤ 2^CNT_W − 1.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  8  level requests; a requester holds its bit high for as long as it uses the resource.
- mask  in  8  per-requester enable; an effective request is req & mask.
- grant  out  8  one-hot grant, equal to decode(grant_idx) when grant_valid, else 0.
- grant_idx  out  3  current or last granted index; retains its value when not valid.
- grant_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Effective request: ereq = req & mask.
- Rotating pointer ptr[2:0], reset 0. Search order is ptr, ptr+1, … ptr+7 (mod 8); the first set ereq bit wins.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If ereq ≠ 0 → GRANT. grant_idx ← winner, grant_valid ← 1, hold_cnt ← 1.
  - Else stay in IDLE.
- GRANT, evaluated at every edge, in priority order:
  1. ereq[grant_idx] = 0 (requester dropped or masked) → GAP. No timeout.
  2. MAX_HOLD ≠ 0 and hold_cnt = MAX_HOLD → GAP. timeout ← 1 for exactly one cycle.
  3. Otherwise hold_cnt ← hold_cnt + 1 and stay in GRANT.
- On leaving GRANT: ptr ← grant_idx + 1 (7 wraps to 0), grant_valid ← 0, grant ← 0.
- GAP lasts exactly one cycle with all grants low. Arbitration runs in GAP with the same rule as IDLE, using the updated ptr.
  - Winner exists → GRANT.
  - No winner → IDLE.
- A timed-out requester still holding req gets its next grant only after every other effective requester has been served once.
- Changes to req or mask on non-granted bits never disturb an active grant.
- hold_cnt saturates; it never wraps.

## Timing
- All outputs are registered.
- Reset values: grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0; internal state: ptr = 0, state = IDLE, hold_cnt = 0.
- Asserting rst_n low, including in the middle of a grant, clears everything immediately without waiting for a clock.
- Latency from IDLE: an ereq bit first sampled high at edge N gives grant high from edge N.
- Release latency: if the owner's req is sampled low at edge M, grant goes low at edge M. A requester holding req for K sampled cycles therefore receives exactly K grant cycles.
- Timeout: with req held, grant is high exactly MAX_HOLD cycles. timeout is high in the first GAP cycle.
- Back-to-back grants: exactly one dead cycle between them. With continuous contention the per-grant period is MAX_HOLD + 1 cycles.
- Simultaneous events: if release and hold limit coincide, release wins and timeout stays 0.

## Test plan
- Reset: hold rst_n = 0 with req = 8'hFF → grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0. Release reset with req = 0 → outputs stay 0.
- Single request: MAX_HOLD = 15, req[5] high for 3 sampled edges → grant = 8'b0010_0000 and grant_idx = 5 for exactly 3 cycles starting at the first sampling edge, then 0. Next winner search starts at 6.
- Full contention: MAX_HOLD = 4, req = 8'hFF held → grants go 0, 1, … 7, 0 in order. Each lasts 4 cycles followed by 1 gap cycle, and timeout pulses once per grant (period 5).
- Wrap-around: after requester 7 releases (ptr = 0), req = 8'b1000_0001 → requester 0 is granted after the gap cycle.
- Mask revoke: grant active on requester 2, mask[2] cleared → grant drops at the next edge with timeout = 0, and the next requester in search order is granted after one gap cycle.
- Asynchronous reset mid-grant: rst_n pulled low between edges during a grant to requester 4 → grant = 0 immediately. After reset, req[3] and req[6] are both high → requester 3 wins first (ptr = 0).
